y_seq_ctrl: RTL and testbench
=============================

Name: y_seq_ctrl

Overview:
- Sequential control unit that drives the single-cycle datapath (yIF/yID/yEX) in place of a hand-written bench loop.
- Owns the PC and steps each instruction through FETCH, DECODE, EXEC and WB.
- Decodes the opcode and funct fields into RegWrite/ALUSrc/op and counts retired instructions.
- Halts on reaching the instruction limit or on an illegal opcode.

Parameters:
- ENTRY, 32'h28, PC value loaded on start.
- MAX_INS, 11, number of instructions retired before entering HALT; 0 means run forever.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; from IDLE, loads PC=ENTRY and begins fetching
- ins  input  32  instruction from yIF, valid in DECODE
- PCp4  input  32  PC+4 from yIF
- branch  input  32  branch target from yID (used only with BRANCH_EN)
- jTarget  input  32  jal target from yID (used only with BRANCH_EN)
- zero  input  1  ALU zero flag from yEX, valid in EXEC
- PC  output  32  current instruction address
- fetch  output  1  high in FETCH only; datapath fetch strobe
- RegWrite  output  1  register-file write enable
- ALUSrc  output  1  0 = rd2, 1 = imm
- op  output  3  ALU operation
- ins_count  output  16  retired instruction count
- busy  output  1  high in FETCH, DECODE, EXEC and WB
- done  output  1  high in HALT
- illegal  output  1  sticky; set on an unknown opcode

Behaviour:
- Reset (asynchronous, any state): state=IDLE, PC=0, RegWrite=0, ALUSrc=0, op=3'b010, fetch=0, ins_count=0, illegal=0, busy=0, done=0.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT. Each instruction takes exactly 4 cycles.
- IDLE:
  - start=1 -> PC<=ENTRY, go to FETCH.
  - start=0 -> stay.
- FETCH: fetch=1; go to DECODE.
- DECODE: register the control outputs from ins[6:0]; they are held through EXEC and WB.
  - 7'h33 (R-type): ALUSrc=0. op from {funct7[5],funct3}: 0_000 add=010, 1_000 sub=110, 0_111 and=000, 0_110 or=001, 0_010 slt=111. Any other R combination is illegal.
  - 7'h03 / 7'h13 (I-type): ALUSrc=1, op=010.
  - 7'h6F (UJ): ALUSrc=1, op=010.
  - 7'h23 (S-type): ALUSrc=1, op=010; no register write.
  - 7'h63 (SB-type): ALUSrc=0, op=110; no register write.
  - Any other opcode: illegal<=1, go directly to HALT with no write and no count increment.
  - Legal opcode -> EXEC.
- EXEC: wait one cycle for ALU settle; go to WB.
- WB:
  - RegWrite=1 for one cycle only for R, I and UJ types.
  - PC<=next PC; ins_count<=ins_count+1.
  - If MAX_INS!=0 and the new count equals MAX_INS -> HALT; else -> FETCH.
- RegWrite is 0 in every state other than WB.
- HALT: done=1; outputs hold. start=1 clears ins_count and illegal, loads PC=ENTRY and goes to FETCH.
- start outside IDLE and HALT is ignored.
- ins_count wraps modulo 2^16 when MAX_INS=0.
- PC is always 32 bits; no alignment check.

Optional Feature:
- Macro: Y_SEQ_CTRL_BRANCH_EN.
- Defined: the WB next-PC is selected as follows:
  - UJ: jTarget.
  - SB with zero sampled at end of EXEC equal to 1: branch.
  - Otherwise: PCp4.
- Undefined: next-PC is always PCp4; branch, jTarget and zero are unused.

Test Plan:
- Reset mid-EXEC with PC=32'h30 -> same cycle: state IDLE, PC=0, RegWrite=0, ins_count=0, busy=0.
- start with ins=32'h002081B3 (add x3,x1,x2) -> FETCH at cycle 1, DECODE ALUSrc=0 op=010, RegWrite=1 only in WB (cycle 4), PC 28->2C, ins_count=1.
- ins=32'h40208233 (sub) then 32'h00500293 (addi) -> op=110 ALUSrc=0, then op=010 ALUSrc=1; both write in WB.
- Stream of 11 legal instructions, MAX_INS=11 -> done=1 after the 44th cycle from start, ins_count=11, PC=32'h54.
- ins=32'h0000007F -> illegal=1, HALT, ins_count unchanged, RegWrite never asserted; then start -> illegal=0, PC=32'h28.
- With Y_SEQ_CTRL_BRANCH_EN: beq, zero=1, branch=32'h40 -> PC=32'h40, RegWrite=0. With zero=0 -> PC=PCp4. Without the macro, the same stimulus gives PC=PCp4.

Source files
------------

// File: rtl/y_seq_ctrl.sv
// y_seq_ctrl: multi-cycle sequencer for the yIF/yID/yEX datapath.
// Optional macro Y_SEQ_CTRL_BRANCH_EN enables jal/beq next-PC selection.
module y_seq_ctrl #(
  parameter logic [31:0] ENTRY   = 32'h28,
  parameter int          MAX_INS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic [31:0] PCp4,
  input  logic [31:0] branch,
  input  logic [31:0] jTarget,
  input  logic        zero,
  output logic [31:0] PC,
  output logic        fetch,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [2:0]  op,
  output logic [15:0] ins_count,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]  state;
  logic        wr_q;
  logic [15:0] cnt_nx;
  logic        halt_at;
  logic [31:0] pc_nx;

  logic       dec_ok;
  logic       dec_src;
  logic [2:0] dec_op;
  logic       dec_wr;
  logic       dec_uj;
  logic       dec_sb;

  logic unused_ins;
  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  assign cnt_nx  = ins_count + 16'd1;
  assign halt_at = (MAX_INS != 0) && (cnt_nx == 16'(MAX_INS));

  // Opcode/funct decode into the control word latched in DECODE
  always_comb begin
    dec_ok  = 1'b1;
    dec_src = 1'b1;
    dec_op  = 3'b010;
    dec_wr  = 1'b0;
    dec_uj  = 1'b0;
    dec_sb  = 1'b0;
    case (ins[6:0])
      7'h33: begin
        dec_src = 1'b0;
        dec_wr  = 1'b1;
        case ({ins[30], ins[14:12]})
          4'b0000: dec_op = 3'b010;
          4'b1000: dec_op = 3'b110;
          4'b0111: dec_op = 3'b000;
          4'b0110: dec_op = 3'b001;
          4'b0010: dec_op = 3'b111;
          default: dec_ok = 1'b0;
        endcase
      end
      7'h03, 7'h13: dec_wr = 1'b1;
      7'h6F: begin
        dec_wr = 1'b1;
        dec_uj = 1'b1;
      end
      7'h23: dec_wr = 1'b0;
      7'h63: begin
        dec_src = 1'b0;
        dec_op  = 3'b110;
        dec_sb  = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

`ifdef Y_SEQ_CTRL_BRANCH_EN
  logic uj_q;
  logic sb_q;
  logic zero_q;

  // Remember the instruction class and the ALU zero flag for WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uj_q   <= 1'b0;
      sb_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (state == S_DECODE) begin
        uj_q <= dec_uj;
        sb_q <= dec_sb;
      end
      if (state == S_EXEC)
        zero_q <= zero;
    end
  end

  // Next-PC select: jal target, taken branch, or fall through
  always_comb begin
    pc_nx = PCp4;
    if (uj_q)
      pc_nx = jTarget;
    else if (sb_q && zero_q)
      pc_nx = branch;
  end
`else
  logic unused_br;
  assign unused_br = ^{branch, jTarget, zero, dec_uj, dec_sb};

  // Straight-line sequencing only
  always_comb pc_nx = PCp4;
`endif

  // Main sequencer: state, PC, control word, counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      PC        <= 32'h0;
      ALUSrc    <= 1'b0;
      op        <= 3'b010;
      wr_q      <= 1'b0;
      ins_count <= 16'h0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            PC    <= ENTRY;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (dec_ok) begin
            ALUSrc <= dec_src;
            op     <= dec_op;
            wr_q   <= dec_wr;
            state  <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            wr_q    <= 1'b0;
            state   <= S_HALT;
          end
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          PC        <= pc_nx;
          ins_count <= cnt_nx;
          state     <= halt_at ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            ins_count <= 16'h0;
            illegal   <= 1'b0;
            PC        <= ENTRY;
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // State-derived strobes; write enable is confined to WB
  always_comb begin
    fetch    = (state == S_FETCH);
    busy     = (state == S_FETCH) || (state == S_DECODE) ||
               (state == S_EXEC) || (state == S_WB);
    done     = (state == S_HALT);
    RegWrite = (state == S_WB) && wr_q;
  end

endmodule

// File: tb/tb_y_seq_ctrl.sv
// tb_y_seq_ctrl: directed checks of the y_seq_ctrl sequencer.
// Expected values are hand-derived from the instruction encodings.
module tb_y_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] ins;
  logic [31:0] PCp4;
  logic [31:0] branch;
  logic [31:0] jTarget;
  logic        zero;
  logic [31:0] PC;
  logic        fetch;
  logic        RegWrite;
  logic        ALUSrc;
  logic [2:0]  op;
  logic [15:0] ins_count;
  logic        busy;
  logic        done;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef Y_SEQ_CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  y_seq_ctrl #(.ENTRY(32'h28), .MAX_INS(11)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ins(ins),
    .PCp4(PCp4),
    .branch(branch),
    .jTarget(jTarget),
    .zero(zero),
    .PC(PC),
    .fetch(fetch),
    .RegWrite(RegWrite),
    .ALUSrc(ALUSrc),
    .op(op),
    .ins_count(ins_count),
    .busy(busy),
    .done(done),
    .illegal(illegal)
  );

  // Stand-in for yIF's PC+4 adder
  assign PCp4 = PC + 32'd4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] t_ins [11];
  logic [2:0]  t_op  [11];
  logic        t_src [11];
  logic        t_wr  [11];

  initial begin
    t_ins = '{32'h002081B3, 32'h40208233, 32'h00500293, 32'h0000A103,
              32'h00112023, 32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3,
              32'h00208063, 32'h00100093, 32'h0000006F};
    t_op  = '{3'b010, 3'b110, 3'b010, 3'b010, 3'b010, 3'b000,
              3'b001, 3'b111, 3'b110, 3'b010, 3'b010};
    t_src = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t_wr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
              1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    reset   = 1'b1;
    start   = 1'b0;
    ins     = 32'h0;
    branch  = 32'h0;
    jTarget = 32'h0;
    zero    = 1'b0;
    tick();

    chk("rst_pc", PC, 32'h0);
    chk("rst_rw", 32'(RegWrite), 32'h0);
    chk("rst_src", 32'(ALUSrc), 32'h0);
    chk("rst_op", 32'(op), 32'h2);
    chk("rst_cnt", 32'(ins_count), 32'h0);
    chk("rst_fetch", 32'(fetch), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ill", 32'(illegal), 32'h0);

    reset = 1'b0;
    ins   = 32'h002081B3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("add_fetch", 32'(fetch), 32'h1);
    chk("add_busy", 32'(busy), 32'h1);
    chk("add_pc0", PC, 32'h28);
    tick();
    chk("add_dec_fetch", 32'(fetch), 32'h0);
    tick();
    chk("add_src", 32'(ALUSrc), 32'h0);
    chk("add_op", 32'(op), 32'h2);
    chk("add_rw_ex", 32'(RegWrite), 32'h0);
    tick();
    chk("add_rw_wb", 32'(RegWrite), 32'h1);
    chk("add_pc_wb", PC, 32'h28);
    tick();
    chk("add_pc1", PC, 32'h2C);
    chk("add_cnt", 32'(ins_count), 32'h1);
    chk("add_rw_f", 32'(RegWrite), 32'h0);

    ins = 32'h40208233;
    tick();
    tick();
    chk("sub_op", 32'(op), 32'h6);
    chk("sub_src", 32'(ALUSrc), 32'h0);
    tick();
    chk("sub_rw_wb", 32'(RegWrite), 32'h1);
    tick();
    chk("sub_pc", PC, 32'h30);
    chk("sub_cnt", 32'(ins_count), 32'h2);

    ins = 32'h00500293;
    tick();
    tick();
    chk("addi_op", 32'(op), 32'h2);
    chk("addi_src", 32'(ALUSrc), 32'h1);
    chk("addi_pc_ex", PC, 32'h30);

    #1 reset = 1'b1;
    #1;
    chk("arst_pc", PC, 32'h0);
    chk("arst_rw", 32'(RegWrite), 32'h0);
    chk("arst_cnt", 32'(ins_count), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_src", 32'(ALUSrc), 32'h0);
    chk("arst_op", 32'(op), 32'h2);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_pc", PC, 32'h0);

    jTarget = 32'h54;
    branch  = 32'h100;
    zero    = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk("str_pc", PC, 32'h28 + 32'(4 * i));
      chk("str_cnt", 32'(ins_count), 32'(i));
      chk("str_fetch", 32'(fetch), 32'h1);
      ins = t_ins[i];
      tick();
      tick();
      chk("str_op", 32'(op), 32'(t_op[i]));
      chk("str_src", 32'(ALUSrc), 32'(t_src[i]));
      chk("str_rw_ex", 32'(RegWrite), 32'h0);
      tick();
      chk("str_rw_wb", 32'(RegWrite), 32'(t_wr[i]));
      tick();
    end
    chk("max_done", 32'(done), 32'h1);
    chk("max_busy", 32'(busy), 32'h0);
    chk("max_cnt", 32'(ins_count), 32'd11);
    chk("max_pc", PC, 32'h54);
    chk("max_rw", 32'(RegWrite), 32'h0);
    tick();
    chk("hold_done", 32'(done), 32'h1);
    chk("hold_pc", PC, 32'h54);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_cnt", 32'(ins_count), 32'h0);
    chk("rs_pc", PC, 32'h28);
    ins = 32'h002081B3;
    tick();
    tick();
    tick();
    tick();
    chk("pre_ill_cnt", 32'(ins_count), 32'h1);
    ins = 32'h0000007F;
    tick();
    chk("ill_dec_rw", 32'(RegWrite), 32'h0);
    tick();
    chk("ill_flag", 32'(illegal), 32'h1);
    chk("ill_done", 32'(done), 32'h1);
    chk("ill_cnt", 32'(ins_count), 32'h1);
    chk("ill_rw", 32'(RegWrite), 32'h0);
    chk("ill_busy", 32'(busy), 32'h0);
    chk("ill_pc", PC, 32'h2C);
    tick();
    chk("ill_hold_rw", 32'(RegWrite), 32'h0);
    chk("ill_sticky", 32'(illegal), 32'h1);

    start = 1'b1;
    tick();
    chk("clr_ill", 32'(illegal), 32'h0);
    chk("clr_pc", PC, 32'h28);
    chk("clr_cnt", 32'(ins_count), 32'h0);
    ins = 32'h0020C1B3;
    tick();
    start = 1'b0;
    chk("ign_start_pc", PC, 32'h28);
    chk("ign_start_busy", 32'(busy), 32'h1);
    tick();
    chk("illr_flag", 32'(illegal), 32'h1);
    chk("illr_done", 32'(done), 32'h1);

    start = 1'b1;
    tick();
    start  = 1'b0;
    ins    = 32'h00208063;
    branch = 32'h40;
    zero   = 1'b1;
    tick();
    tick();
    tick();
    chk("beq_t_rw", 32'(RegWrite), 32'h0);
    tick();
    chk("beq_t_pc", PC, BR_EN ? 32'h40 : 32'h2C);
    zero = 1'b0;
    tick();
    tick();
    tick();
    chk("beq_n_rw", 32'(RegWrite), 32'h0);
    tick();
    chk("beq_n_pc", PC, BR_EN ? 32'h44 : 32'h30);
    chk("beq_cnt", 32'(ins_count), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
